// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD frame arbiter: FSM state encoding,
// byte width and default frame/gap sizing.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int BYTE_W          = 8;
  localparam int DEF_FRAME_BYTES = 1024;
  localparam int DEF_GAP_CYCLES  = 16;

  // Width of a source index; a single-source build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_frame_arbiter_if.sv
// Byte-stream bundle between the frame sources, the arbiter and LCD_control.
// A byte moves on any cycle where its valid and ready are both high; ready is
// combinational from the arbiter and valid must not depend on ready.
interface lcd_frame_arbiter_if #(
  parameter int NSRC = 2
);
  import lcd_arb_pkg::*;

  logic [NSRC-1:0]        src_req;
  logic [BYTE_W*NSRC-1:0] src_data;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC-1:0]        src_done;
  logic [BYTE_W-1:0]      lcd_data;
  logic                   lcd_valid;
  logic                   lcd_ready;

  modport master (
    output src_req, src_data, src_valid, lcd_ready,
    input  src_ready, src_done, lcd_data, lcd_valid
  );

  modport slave (
    input  src_req, src_data, src_valid, lcd_ready,
    output src_ready, src_done, lcd_data, lcd_valid
  );

endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the
// last owner, wrapping around the source vector.
module lcd_rr_pick
  import lcd_arb_pkg::*;
#(
  parameter  int NSRC  = 2,
  localparam int IDX_W = idx_w(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NSRC-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      if (!any && req[(int'(last) + k) % NSRC]) begin
        any                            = 1'b1;
        pick[(int'(last) + k) % NSRC]  = 1'b1;
        pick_idx                       = IDX_W'((int'(last) + k) % NSRC);
      end
    end
  end

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing the LCD_control byte stream.
// Optional per-source completed-frame counters: define LCD_ARB_FRAME_CNT_EN.
module lcd_frame_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_frame_arbiter_if.slave  bus,
  output logic [NSRC-1:0]     grant,
  output logic                busy,
`ifdef LCD_ARB_FRAME_CNT_EN
  output logic [8*NSRC-1:0]   frame_cnt,
`endif
  output arb_state_t          state_dbg
);

  localparam int IDX_W = idx_w(NSRC);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [NSRC-1:0]   pick;
  logic              any_req;
  logic [NSRC-1:0]   done_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              in_xfer;
  logic              accept;

  lcd_rr_pick #(.NSRC(NSRC)) u_pick (
    .req      (bus.src_req),
    .last     (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any_req)
  );

  // Zero-latency datapath; everything is held at zero outside XFER.
  assign in_xfer       = (state == XFER);
  assign bus.lcd_data  = in_xfer ? bus.src_data[owner*BYTE_W +: BYTE_W] : '0;
  assign bus.lcd_valid = in_xfer && grant[owner] && bus.src_valid[owner];
  assign bus.src_ready = (in_xfer && bus.lcd_ready) ? grant : '0;
  assign bus.src_done  = done_q;
  assign accept        = bus.lcd_valid && bus.lcd_ready;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= IDX_W'(NSRC - 1);
      byte_cnt <= '0;
      gap_cnt  <= '0;
      done_q   <= '0;
      busy     <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= XFER;
            grant    <= pick;
            owner    <= pick_idx;
            byte_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        XFER: begin
          // Requests are not looked at here: a started frame always completes.
          if (accept) begin
            if (byte_cnt == LAST_BYTE) begin
              state   <= GAP;
              grant   <= '0;
              done_q  <= grant;
              rr_ptr  <= owner;
              gap_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_ARB_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (done_q[i]) frame_cnt[i*8 +: 8] <= frame_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
